branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_pkg.sv | 28 ++
 rtl/branch_target_buffer.sv | 54 +++++
 rtl/branch_predictor.sv | 74 +++++++
 tb/tb_branch_predictor.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch predictor: datapath width and the
// 2-bit saturating counter type used by the pattern history table.
package branch_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        SU = 2'b00,
        WU = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } counter_t;

    // Saturating step: never wraps from ST to SU or from SU to ST.
    function automatic counter_t counter_next(input counter_t ctr, input logic taken);
        counter_t result;
        result = ctr;
        unique case (ctr)
            SU: result = taken ? WU : SU;
            WU: result = taken ? WT : SU;
            WT: result = taken ? ST : WU;
            ST: result = taken ? ST : WT;
            default: result = WU;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with one combinational lookup port
// and one synchronous write port; only the valid bits are reset.
module branch_target_buffer
    import branch_pkg::*;
#(
    parameter int INDEX_WIDTH = 4
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic [XLEN-1:2] lookup_pc_i,
    output logic            hit_o,
    output logic [XLEN-1:0] target_o,
    input  logic            write_en_i,
    input  logic [XLEN-1:2] write_pc_i,
    input  logic [XLEN-1:0] write_target_i
);

    localparam int ENTRIES   = 2 ** INDEX_WIDTH;
    localparam int TAG_WIDTH = XLEN - 2 - INDEX_WIDTH;

    logic [ENTRIES-1:0]   valid_q;
    logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]      target_q [ENTRIES];

    logic [INDEX_WIDTH-1:0] lookup_idx;
    logic [TAG_WIDTH-1:0]   lookup_tag;
    logic [INDEX_WIDTH-1:0] write_idx;
    logic [TAG_WIDTH-1:0]   write_tag;

    assign lookup_idx = lookup_pc_i[INDEX_WIDTH+1:2];
    assign lookup_tag = lookup_pc_i[XLEN-1:INDEX_WIDTH+2];
    assign write_idx  = write_pc_i[INDEX_WIDTH+1:2];
    assign write_tag  = write_pc_i[XLEN-1:INDEX_WIDTH+2];

    assign hit_o    = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign target_o = target_q[lookup_idx];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q <= '0;
        end else if (write_en_i) begin
            valid_q[write_idx] <= 1'b1;
        end
    end

    // Tag and target storage carries no reset; a cleared valid bit masks it.
    always_ff @(posedge clk_i) begin
        if (write_en_i) begin
            tag_q[write_idx]    <= write_tag;
            target_q[write_idx] <= write_target_i;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: PHT of 2-bit counters plus a direct-mapped BTB,
// with combinational fetch prediction and execute-stage mispredict detection.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int INDEX_WIDTH     = 6,
    parameter int BTB_INDEX_WIDTH = 4
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic [XLEN-1:0] pc_f_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic [XLEN-1:0] pc_e_i,
    input  logic            branch_e_i,
    input  logic            stall_e_i,
    input  logic            pc_src_res_e_i,
    input  logic [XLEN-1:0] target_e_i,
    input  logic            pred_taken_e_i,
    input  logic [XLEN-1:0] pred_target_e_i,
    output logic            mispredict_o,
    output logic [XLEN-1:0] correct_pc_o
);

    localparam int PHT_ENTRIES = 2 ** INDEX_WIDTH;

    counter_t pht_q [PHT_ENTRIES];

    logic [INDEX_WIDTH-1:0] f_idx;
    logic [INDEX_WIDTH-1:0] e_idx;
    counter_t               f_ctr;
    logic                   update_en;
    logic                   btb_hit;
    logic [XLEN-1:0]        btb_target;

    assign f_idx     = pc_f_i[INDEX_WIDTH+1:2];
    assign e_idx     = pc_e_i[INDEX_WIDTH+1:2];
    assign f_ctr     = pht_q[f_idx];
    assign update_en = branch_e_i & ~stall_e_i;

    branch_target_buffer #(
        .INDEX_WIDTH(BTB_INDEX_WIDTH)
    ) u_btb (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .lookup_pc_i   (pc_f_i[XLEN-1:2]),
        .hit_o         (btb_hit),
        .target_o      (btb_target),
        .write_en_i    (update_en & pc_src_res_e_i),
        .write_pc_i    (pc_e_i[XLEN-1:2]),
        .write_target_i(target_e_i)
    );

    // Reads see pre-update state: no bypass from the resolving branch.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= WU;
            end
        end else if (update_en) begin
            pht_q[e_idx] <= counter_next(pht_q[e_idx], pc_src_res_e_i);
        end
    end

    assign pred_taken_o  = f_ctr[1] & btb_hit;
    assign pred_target_o = btb_hit ? btb_target : pc_f_i + XLEN'(4);

    // A taken/taken pair still mispredicts when the carried target is stale.
    assign mispredict_o = update_en &
                          ((pred_taken_e_i != pc_src_res_e_i) |
                           (pred_taken_e_i & pc_src_res_e_i & (pred_target_e_i != target_e_i)));
    assign correct_pc_o = pc_src_res_e_i ? target_e_i : pc_e_i + XLEN'(4);

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expectations are queued as stimulus is
// driven and drained against the DUT outputs half a cycle away from the edge.
module tb_branch_predictor;

    logic        clk_i;
    logic        reset_n_i;
    logic [31:0] pc_f_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic [31:0] pc_e_i;
    logic        branch_e_i;
    logic        stall_e_i;
    logic        pc_src_res_e_i;
    logic [31:0] target_e_i;
    logic        pred_taken_e_i;
    logic [31:0] pred_target_e_i;
    logic        mispredict_o;
    logic [31:0] correct_pc_o;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] value;
    } expect_t;

    expect_t sb_q[$];
    int      vectors;
    int      miscompares;

    branch_predictor #(
        .INDEX_WIDTH    (6),
        .BTB_INDEX_WIDTH(4)
    ) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .pc_f_i         (pc_f_i),
        .pred_taken_o   (pred_taken_o),
        .pred_target_o  (pred_target_o),
        .pc_e_i         (pc_e_i),
        .branch_e_i     (branch_e_i),
        .stall_e_i      (stall_e_i),
        .pc_src_res_e_i (pc_src_res_e_i),
        .target_e_i     (target_e_i),
        .pred_taken_e_i (pred_taken_e_i),
        .pred_target_e_i(pred_target_e_i),
        .mispredict_o   (mispredict_o),
        .correct_pc_o   (correct_pc_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return {31'b0, pred_taken_o};
            1:       return pred_target_o;
            2:       return {31'b0, mispredict_o};
            default: return correct_pc_o;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [31:0] value);
        expect_t e;
        e.tag   = tag;
        e.sel   = sel;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic check_output();
        expect_t     e;
        logic [31:0] obs;
        #1;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.sel);
            vectors++;
            assert (obs === e.value) else begin
                miscompares++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic apply_stimulus(input logic branch, input logic stall, input logic [31:0] pc,
                                  input logic taken, input logic [31:0] target,
                                  input logic ptaken, input logic [31:0] ptarget);
        branch_e_i      = branch;
        stall_e_i       = stall;
        pc_e_i          = pc;
        pc_src_res_e_i  = taken;
        target_e_i      = target;
        pred_taken_e_i  = ptaken;
        pred_target_e_i = ptarget;
    endtask

    task automatic expect_pred(input string tag, input logic [31:0] pc,
                               input logic taken, input logic [31:0] target);
        @(negedge clk_i);
        pc_f_i = pc;
        expect_out({tag, "_taken"}, 0, {31'b0, taken});
        expect_out({tag, "_target"}, 1, target);
        check_output();
    endtask

    task automatic expect_resolve(input string tag, input logic mis, input logic [31:0] cpc);
        expect_out({tag, "_mispredict"}, 2, {31'b0, mis});
        expect_out({tag, "_correct_pc"}, 3, cpc);
        check_output();
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] target);
        @(negedge clk_i);
        apply_stimulus(1'b1, 1'b0, pc, taken, target, 1'b0, 32'h0);
        @(negedge clk_i);
        branch_e_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_n_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n_i   = 1'b0;
        pc_f_i      = 32'h0;
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #12;
        @(negedge clk_i);
        reset_n_i = 1'b1;

        $display("[TB] reset and first taken update");
        expect_pred("reset_pred", 32'h100, 1'b0, 32'h104);
        expect_resolve("idle", 1'b0, 32'h4);
        train(32'h100, 1'b1, 32'h200);
        expect_pred("taken_once", 32'h100, 1'b1, 32'h200);

        $display("[TB] BTB aliasing");
        expect_pred("alias_miss", 32'h500, 1'b0, 32'h504);
        train(32'h500, 1'b1, 32'h600);
        expect_pred("alias_evicted", 32'h100, 1'b0, 32'h104);
        expect_pred("alias_hit", 32'h500, 1'b1, 32'h600);

        $display("[TB] counter saturation");
        do_reset();
        train(32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b1, 32'h200);
        expect_pred("strong_taken", 32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b0, 32'h0);
        expect_pred("st_to_wt", 32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b0, 32'h0);
        expect_pred("wt_to_wu", 32'h100, 1'b0, 32'h200);
        train(32'h100, 1'b0, 32'h0);
        train(32'h100, 1'b0, 32'h0);
        train(32'h100, 1'b1, 32'h200);
        expect_pred("su_to_wu", 32'h100, 1'b0, 32'h200);
        train(32'h100, 1'b1, 32'h200);
        expect_pred("wu_to_wt", 32'h100, 1'b1, 32'h200);

        $display("[TB] same-cycle read sees old state");
        @(negedge clk_i);
        apply_stimulus(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        pc_f_i = 32'h100;
        expect_out("no_bypass_taken", 0, 32'h1);
        expect_out("no_bypass_target", 1, 32'h200);
        check_output();
        @(negedge clk_i);
        branch_e_i = 1'b0;
        expect_pred("after_bypass", 32'h100, 1'b0, 32'h200);

        $display("[TB] stall suppresses update and flush");
        @(negedge clk_i);
        apply_stimulus(1'b1, 1'b1, 32'h144, 1'b1, 32'h700, 1'b0, 32'h0);
        expect_resolve("stall", 1'b0, 32'h700);
        @(negedge clk_i);
        expect_pred("stall_hold", 32'h144, 1'b0, 32'h148);
        stall_e_i = 1'b0;
        expect_resolve("unstall", 1'b1, 32'h700);
        @(negedge clk_i);
        branch_e_i = 1'b0;
        expect_pred("unstall_learn", 32'h144, 1'b1, 32'h700);

        $display("[TB] mispredict variants");
        @(negedge clk_i);
        apply_stimulus(1'b1, 1'b0, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
        expect_resolve("target_mis", 1'b1, 32'h300);
        apply_stimulus(1'b1, 1'b0, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        expect_resolve("target_match", 1'b0, 32'h200);
        apply_stimulus(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
        expect_resolve("wrap_nt", 1'b1, 32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h180, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_resolve("nt_correct", 1'b0, 32'h184);
        branch_e_i = 1'b0;

        $display("[TB] reset mid-training");
        train(32'h100, 1'b1, 32'h200);
        expect_pred("pre_reset", 32'h100, 1'b1, 32'h200);
        @(negedge clk_i);
        reset_n_i = 1'b0;
        apply_stimulus(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        pc_f_i = 32'h100;
        expect_out("in_reset_taken", 0, 32'h0);
        expect_out("in_reset_target", 1, 32'h104);
        expect_resolve("in_reset", 1'b1, 32'h104);
        branch_e_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        expect_pred("post_reset_100", 32'h100, 1'b0, 32'h104);
        expect_pred("post_reset_144", 32'h144, 1'b0, 32'h148);
        train(32'h100, 1'b1, 32'h200);
        expect_pred("post_reset_learn", 32'h100, 1'b1, 32'h200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
